ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Counterpart of the existing ps2 keyboard receiver. Shares the same PS2_clk/PS2_data open-drain lines through top-level tri-state buffers.
- Runs on clk_100mhz beside the receiver. MIO_BUS pulses start with a byte; CPU polls busy/done/ack_ok/err.
- Asserts tx_active so the receiver ignores the frame clocked during transmission.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles PS2 clock held low before request (120 us @100 MHz)
TIMEOUT_CYCLES, 1500000, max clk cycles between device clock falling edges before abort (15 ms)
FILTER_LEN, 8, consecutive identical samples required to accept a new line level

Ports:
clk  in  1  system clock (100 MHz)
RSTN  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
tx_data  in  8  byte to send, captured the cycle start is accepted
ps2_clk_in  in  1  raw PS2 clock line level (asynchronous)
ps2_data_in  in  1  raw PS2 data line level (asynchronous)
ps2_clk_oe  out  1  1 = drive PS2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS2 data low, 0 = release
busy  out  1  transaction in progress
tx_active  out  1  equals busy; receiver inhibit
done  out  1  one-cycle pulse at end of every transaction
ack_ok  out  1  device acknowledged last frame; valid from done until next start
err  out  1  last transaction aborted by timeout; valid from done until next start

Behaviour:
- Reset (RSTN=0, asynchronous): all outputs 0, both lines released, state IDLE, counters 0, filters preset to 1. Reset mid-frame releases lines immediately.
- Line conditioning: each raw input goes through a 2-flop synchronizer, then a FILTER_LEN stability filter. clk_fall is a one-cycle pulse on filtered clock 1->0.
- Frame: start bit 0, d[0]..d[7] LSB first, odd parity (~^tx_data), stop bit 1, device ACK.
- Line driving: data_oe = ~current_bit. Releasing the line sends 1.
- IDLE: start=1 captures tx_data into a shift register and clears ack_ok and err. Next cycle: busy=1, state INHIBIT, clk_oe=1.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then state REQ.
- REQ: one cycle with clk_oe=1 and data_oe=1 (start bit). Then state SHIFT with clk_oe=0, data_oe held at 1.
- SHIFT: bit counter n=1..10 advances on each clk_fall.
  - n=1..8 drives d[n-1].
  - n=9 drives parity.
  - n=10 releases data (stop bit), then state ACK.
- ACK: on the next clk_fall, sample filtered data: ack_ok = (data==0). Then state WAIT_IDLE.
- WAIT_IDLE: when filtered clock and data are both 1, pulse done, clear busy, go to IDLE.
- A frame with no ACK completes with ack_ok=0, err=0.
- Timeout: in SHIFT, ACK and WAIT_IDLE, a counter clears on each clk_fall and on state entry and otherwise increments.
  - Reaching TIMEOUT_CYCLES: release both lines the same cycle, err=1, ack_ok=0, pulse done, go to IDLE.
  - INHIBIT and REQ are not timed.
- Simultaneous events: start while busy=1 is ignored, with no queueing. start in the same cycle done pulses is ignored. A timeout and a clk_fall in the same cycle resolve as clk_fall (counter clears).
- Never drive a line high. The oe outputs are the only line controls.
- Latency: start to clk_oe=1 is 1 cycle. start to data_oe=1 is INHIBIT_CYCLES+1 cycles.

Decomposition:
- Shared header ps2_defs: state encodings (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE), frame constants (DATA_BITS=8, last shift index 10), command constants (CMD_SET_LED=8'hED, CMD_RESET=8'hFF).
- Sub-module ps2_line_filter (synchronizer, stability filter, falling-edge pulse), instantiated for the clock and data lines. Reusable by the receiver.

Test Plan:
Bench setup: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500, FILTER_LEN=2. Device model clocks at 10-16 kHz-scaled period, samples data on clock rising edges, drives ACK low on falling edge 11.
- tx_data=8'hED -> clk_oe low 20 cycles; device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, ack_ok=1, err=0.
- tx_data=8'h01 -> data bits 1,0,0,0,0,0,0,0, parity 0; ack_ok=1. Repeat with 8'h00, parity 1.
- Device model never clocks after REQ -> after 500 idle cycles both oe=0, done=1, err=1, ack_ok=0, busy=0.
- Device clocks the frame but omits ACK -> done=1, ack_ok=0, err=0.
- start re-pulsed with 8'h55 during SHIFT of 8'hED -> frame bits still 0xED; only one done pulse.
- RSTN=0 at n=5 -> oe=0 asynchronously, busy=0; a new start after release sends a full correct frame.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame geometry and common keyboard commands.
// Imported by the host transmitter and reusable by the keyboard receiver.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int DATA_BITS      = 8;
  localparam int LAST_SHIFT_IDX = 10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] i_data);
    return ~^i_data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchronizer, FILTER_LEN-sample stability filter
// and a one-cycle pulse when the filtered level falls from 1 to 0.
module ps2_host_tx_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;

  // An idle PS/2 line is pulled high, so everything presets to 1.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock falls and reports the device acknowledge or a timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_ps2_clk_in,
  input  logic                 i_ps2_data_in,
  output logic                 o_ps2_clk_oe,
  output logic                 o_ps2_data_oe,
  output logic                 o_busy,
  output logic                 o_tx_active,
  output logic                 o_done,
  output logic                 o_ack_ok,
  output logic                 o_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(LAST_SHIFT_IDX - 1);

  logic w_clkLevel, w_clkFall, w_dataLevel, w_unusedDataFall;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_raw   (i_ps2_clk_in),
    .o_level (w_clkLevel),
    .o_fall  (w_clkFall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dataFilter (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_raw   (i_ps2_data_in),
    .o_level (w_dataLevel),
    .o_fall  (w_unusedDataFall)
  );

  ps2_state_e           r_state, w_stateNext;
  logic [CNT_W-1:0]     r_cnt, w_cntNext;
  logic [3:0]           r_bitCnt, w_bitCntNext;
  logic [DATA_BITS:0]   r_shift, w_shiftNext;
  logic r_clkOe, w_clkOeNext, r_dataOe, w_dataOeNext, r_busy, w_busyNext;
  logic r_done, w_doneNext, r_ackOk, w_ackOkNext, r_err, w_errNext;
  logic w_timedState, w_timeout;

  // A clock fall in the same cycle as the timeout wins: the device is still alive.
  assign w_timedState = (r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
  assign w_timeout    = w_timedState && !w_clkFall && (r_cnt == TO_LAST);

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_clkOeNext  = r_clkOe;
    w_dataOeNext = r_dataOe;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_ackOkNext  = r_ackOk;
    w_errNext    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !r_done) begin
          w_shiftNext  = {odd_parity(i_tx_data), i_tx_data};
          w_ackOkNext  = 1'b0;
          w_errNext    = 1'b0;
          w_busyNext   = 1'b1;
          w_clkOeNext  = 1'b1;
          w_dataOeNext = 1'b0;
          w_cntNext    = '0;
          w_stateNext  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cntNext    = '0;
          w_dataOeNext = 1'b1;
          w_stateNext  = ST_REQ;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      ST_REQ: begin
        w_clkOeNext  = 1'b0;
        w_bitCntNext = '0;
        w_cntNext    = '0;
        w_stateNext  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_clkFall) begin
          w_cntNext    = '0;
          w_bitCntNext = r_bitCnt + 4'd1;
          if (r_bitCnt == BIT_LAST) begin
            w_dataOeNext = 1'b0;
            w_stateNext  = ST_ACK;
          end else begin
            w_dataOeNext = ~r_shift[0];
            w_shiftNext  = {1'b0, r_shift[DATA_BITS:1]};
          end
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (w_clkFall) begin
          w_cntNext   = '0;
          w_ackOkNext = ~w_dataLevel;
          w_stateNext = ST_WAIT_IDLE;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clkFall) begin
          w_cntNext = '0;
        end else if (w_clkLevel && w_dataLevel) begin
          w_cntNext   = '0;
          w_doneNext  = 1'b1;
          w_busyNext  = 1'b0;
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_clkOeNext  = 1'b0;
      w_dataOeNext = 1'b0;
      w_errNext    = 1'b1;
      w_ackOkNext  = 1'b0;
      w_doneNext   = 1'b1;
      w_busyNext   = 1'b0;
      w_cntNext    = '0;
      w_stateNext  = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_clkOe  <= 1'b0;
      r_dataOe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ackOk  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_clkOe  <= w_clkOeNext;
      r_dataOe <= w_dataOeNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
      r_ackOk  <= w_ackOkNext;
      r_err    <= w_errNext;
    end
  end

  assign o_ps2_clk_oe  = r_clkOe;
  assign o_ps2_data_oe = r_dataOe;
  assign o_busy        = r_busy;
  assign o_tx_active   = r_busy;
  assign o_done        = r_done;
  assign o_ack_ok      = r_ackOk;
  assign o_err         = r_err;

endmodule
